// File: rtl/fetch_pc_monitor_pkg.sv
// Shared definitions for the fetch-side PC monitor: the status encoding and
// the default pass/fail loop addresses of the standard test image.
package fetch_pc_monitor_pkg;

  localparam int STATUS_W = 3;

  typedef enum logic [STATUS_W-1:0] {
    STATUS_RUN     = 3'd0,
    STATUS_PASS    = 3'd1,
    STATUS_FAIL    = 3'd2,
    STATUS_TIMEOUT = 3'd3,
    STATUS_HANG    = 3'd4
  } status_e;

  localparam logic [31:0] PASS_PC_DEF = 32'h8000_012c;
  localparam logic [31:0] FAIL_PC_DEF = 32'h8000_0130;

  // Any status other than RUN is a sticky end state.
  function automatic logic is_terminal(status_e s);
    return s != STATUS_RUN;
  endfunction

endpackage

// File: rtl/fetch_pc_monitor_sat_cnt.sv
// Generic saturating up-counter: clear wins over increment, and the count
// holds at all ones instead of wrapping.
module fetch_pc_monitor_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_pc_monitor.sv
// Passive observer on the instruction-fetch bus. Watches accepted fetches
// and reports PASS / FAIL / TIMEOUT (and HANG when built with
// FETCH_PC_MONITOR_HANG_DETECT_EN) as a registered, sticky status.
// Nothing here drives back into the core or the memory.
module fetch_pc_monitor
  import fetch_pc_monitor_pkg::*;
#(
  parameter logic [31:0] PASS_PC        = PASS_PC_DEF,
  parameter logic [31:0] FAIL_PC        = FAIL_PC_DEF,
  parameter int          TIMEOUT_CYCLES = 1000,
  parameter int          CYCLE_W        = 16
`ifdef FETCH_PC_MONITOR_HANG_DETECT_EN
  ,
  parameter int          HANG_LIMIT     = 8
`endif
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                fetch_rd_i,
  input  logic                fetch_accept_i,
  input  logic [31:0]         fetch_pc_i,
  input  logic                clear_i,
  output logic [STATUS_W-1:0] status_o,
  output logic                done_o,
  output logic [CYCLE_W-1:0]  cycle_count_o,
  output logic [CYCLE_W-1:0]  fetch_count_o,
  output logic [31:0]         last_pc_o,
  output logic                pc_change_o
);

  // Value of the cycle counter on the last RUN cycle before a timeout.
  localparam logic [CYCLE_W-1:0] TIMEOUT_LAST = CYCLE_W'(TIMEOUT_CYCLES - 1);

  status_e     state_q, state_d;
  logic        done_q, done_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic        pc_change_q, pc_change_d;

  logic               acc, in_run, same_pc, is_pass, is_fail;
  logic               timeout_hit, hang_hit;
  logic               fetch_upd;
  logic [CYCLE_W-1:0] cycle_cnt, fetch_cnt;

  // Decode the handshake and the events that can end a run.
  always_comb begin
    acc         = fetch_rd_i & fetch_accept_i;
    in_run      = (state_q == STATUS_RUN);
    same_pc     = (fetch_pc_i == last_pc_q);
    is_pass     = acc & (fetch_pc_i == PASS_PC);
    is_fail     = acc & (fetch_pc_i == FAIL_PC);
    timeout_hit = (cycle_cnt == TIMEOUT_LAST);
    // A fetch only updates the tracked state while running and not clearing.
    fetch_upd   = in_run & acc & ~clear_i;
  end

`ifdef FETCH_PC_MONITOR_HANG_DETECT_EN
  // Hang counter counts repeats of last_pc; the fetch that brings it to
  // HANG_LIMIT-1 (i.e. the HANG_LIMIT-th consecutive same-PC fetch) hangs.
  localparam int              HANG_W    = $clog2(HANG_LIMIT) + 1;
  localparam logic [HANG_W-1:0] HANG_LAST = HANG_W'(HANG_LIMIT - 2);

  logic [HANG_W-1:0] hang_cnt;
  logic              hang_inc, hang_clr;

  // Repeats advance the count; any fresh PC (or a clear) restarts it.
  always_comb begin
    hang_inc = fetch_upd & same_pc;
    hang_clr = clear_i | (fetch_upd & ~same_pc);
    hang_hit = acc & same_pc & (hang_cnt == HANG_LAST) & ~is_pass & ~is_fail;
  end

  fetch_pc_monitor_sat_cnt #(.W(HANG_W)) u_hang_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (hang_clr),
    .inc_i (hang_inc),
    .cnt_o (hang_cnt)
  );
`else
  assign hang_hit = 1'b0;
`endif

  // Status transitions: clear beats everything, then PASS > FAIL > HANG > TIMEOUT.
  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = STATUS_RUN;
    end else if (in_run) begin
      if      (is_pass)     state_d = STATUS_PASS;
      else if (is_fail)     state_d = STATUS_FAIL;
      else if (hang_hit)    state_d = STATUS_HANG;
      else if (timeout_hit) state_d = STATUS_TIMEOUT;
    end
    done_d      = is_terminal(state_d);
    last_pc_d   = fetch_upd ? fetch_pc_i : last_pc_q;
    pc_change_d = fetch_upd & ~same_pc;
  end

  // Status, last PC and change pulse registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= STATUS_RUN;
      done_q      <= 1'b0;
      last_pc_q   <= '0;
      pc_change_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      last_pc_q   <= last_pc_d;
      pc_change_q <= pc_change_d;
    end
  end

  // Cycles spent in RUN, including the cycle that leaves it.
  fetch_pc_monitor_sat_cnt #(.W(CYCLE_W)) u_cycle_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .inc_i (in_run),
    .cnt_o (cycle_cnt)
  );

  // Accepted fetches in RUN, including the one that ends the run.
  fetch_pc_monitor_sat_cnt #(.W(CYCLE_W)) u_fetch_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (clear_i),
    .inc_i (fetch_upd),
    .cnt_o (fetch_cnt)
  );

  assign status_o      = state_q;
  assign done_o        = done_q;
  assign cycle_count_o = cycle_cnt;
  assign fetch_count_o = fetch_cnt;
  assign last_pc_o     = last_pc_q;
  assign pc_change_o   = pc_change_q;

endmodule
